// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver: one shared active-low segment bus,
// per-digit active-low enables, frame-synchronous input snapshot and whole-display blink.
module seven_seg_scan_driver #(
    parameter int SCAN_CNT     = 10,
    parameter int DEAD_CNT     = 2,
    parameter int BLINK_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] i_seven0,
    input  logic [6:0] i_seven1,
    input  logic [6:0] i_seven2,
    input  logic [6:0] i_seven3,
    input  logic       i_blink,
    output logic [6:0] o_seg,
    output logic [3:0] o_an,
    output logic       o_frame
);

    localparam int SLOT_W = (SCAN_CNT > 1) ? $clog2(SCAN_CNT) : 1;
    localparam int K_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_CNT - 1);
    localparam logic [SLOT_W-1:0] SLOT_DEAD = SLOT_W'(DEAD_CNT);
    localparam logic [K_W-1:0]    K_LAST    = K_W'(BLINK_FRAMES - 1);
    localparam logic [6:0]        SEG_OFF   = 7'h7F;
    localparam logic [3:0]        AN_OFF    = 4'hF;

    if (DEAD_CNT < 1 || DEAD_CNT >= SCAN_CNT || BLINK_FRAMES < 1) begin : g_param_check
        $error("seven_seg_scan_driver: illegal SCAN_CNT/DEAD_CNT/BLINK_FRAMES");
    end

    // slot_q/digit_q hold the frame position that the next edge presents on the outputs,
    // so the first edge after reset lands on position 0 (a frame start).
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        digit_q, digit_d;
    logic [3:0][6:0]   shadow_q, shadow_d;
    logic              blink_en_q, blink_en_d;
    logic              phase_q, phase_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        an_q, an_d;
    logic              frame_q, frame_d;

    logic              frame_start;
    logic              blank;

    always_comb begin
        frame_start = (slot_q == '0) && (digit_q == 2'd0);

        slot_d  = slot_q;
        digit_d = digit_q;
        if (slot_q == SLOT_LAST) begin
            slot_d  = '0;
            digit_d = digit_q + 2'd1;
        end else begin
            slot_d  = slot_q + SLOT_W'(1);
        end

        shadow_d   = shadow_q;
        blink_en_d = blink_en_q;
        phase_d    = phase_q;
        k_d        = k_q;
        if (frame_start) begin
            shadow_d = {i_seven3, i_seven2, i_seven1, i_seven0};
            if (!i_blink) begin
                blink_en_d = 1'b0;
                k_d        = '0;
                phase_d    = 1'b0;
            end else if (!blink_en_q) begin
                blink_en_d = 1'b1;
                k_d        = '0;
                phase_d    = 1'b0;
            end else if (k_q == K_LAST) begin
                k_d        = '0;
                phase_d    = ~phase_q;
            end else begin
                k_d        = k_q + K_W'(1);
            end
        end

        // Blink state after this edge governs the whole frame, including its first slot.
        blank   = (slot_q < SLOT_DEAD) || (blink_en_d && phase_d);
        seg_d   = blank ? SEG_OFF : shadow_d[digit_q];
        an_d    = blank ? AN_OFF : ~(4'b0001 << digit_q);
        frame_d = frame_start;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q     <= '0;
            digit_q    <= 2'd0;
            shadow_q   <= {4{SEG_OFF}};
            blink_en_q <= 1'b0;
            phase_q    <= 1'b0;
            k_q        <= '0;
            seg_q      <= SEG_OFF;
            an_q       <= AN_OFF;
            frame_q    <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            digit_q    <= digit_d;
            shadow_q   <= shadow_d;
            blink_en_q <= blink_en_d;
            phase_q    <= phase_d;
            k_q        <= k_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            frame_q    <= frame_d;
        end
    end

    assign o_seg   = seg_q;
    assign o_an    = an_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: default-parameter and small-parameter instances checked
// cycle by cycle against a frame-level reference model.
module tb_seven_seg_scan_driver;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    localparam int NI = 2;
    int scan[NI] = '{10, 2};
    int dead[NI] = '{2, 1};
    int bfr[NI]  = '{4, 1};

    logic [6:0] sev[NI][4];
    logic       blink[NI];

    logic [6:0] seg0, seg1;
    logic [3:0] an0, an1;
    logic       fr0, fr1;
    logic [6:0] seg_w[NI];
    logic [3:0] an_w[NI];
    logic       fr_w[NI];
    assign seg_w[0] = seg0;
    assign seg_w[1] = seg1;
    assign an_w[0]  = an0;
    assign an_w[1]  = an1;
    assign fr_w[0]  = fr0;
    assign fr_w[1]  = fr1;

    seven_seg_scan_driver #(.SCAN_CNT(10), .DEAD_CNT(2), .BLINK_FRAMES(4)) u_dflt (
        .clk(clk), .reset_n(reset_n),
        .i_seven0(sev[0][0]), .i_seven1(sev[0][1]), .i_seven2(sev[0][2]), .i_seven3(sev[0][3]),
        .i_blink(blink[0]), .o_seg(seg0), .o_an(an0), .o_frame(fr0)
    );

    seven_seg_scan_driver #(.SCAN_CNT(2), .DEAD_CNT(1), .BLINK_FRAMES(1)) u_small (
        .clk(clk), .reset_n(reset_n),
        .i_seven0(sev[1][0]), .i_seven1(sev[1][1]), .i_seven2(sev[1][2]), .i_seven3(sev[1][3]),
        .i_blink(blink[1]), .o_seg(seg1), .o_an(an1), .o_frame(fr1)
    );

    // Reference model: edges counted since reset release, frame-level snapshot and blink run length
    int         n[NI];
    int         run[NI];
    int         pos[NI];
    logic [6:0] snap[NI][4];
    logic [6:0] exp_seg[NI];
    logic [3:0] exp_an[NI];
    logic       exp_fr[NI];

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            n[i] = 0;
            run[i] = 0;
            pos[i] = 0;
            for (int d = 0; d < 4; d++) snap[i][d] = 7'h7F;
            exp_seg[i] = 7'h7F;
            exp_an[i] = 4'hF;
            exp_fr[i] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            int p;
            int dig;
            bit blank;
            p = n[i] % (4 * scan[i]);
            if (p == 0) begin
                for (int d = 0; d < 4; d++) snap[i][d] = sev[i][d];
                run[i] = blink[i] ? run[i] + 1 : 0;
            end
            dig = p / scan[i];
            blank = ((p % scan[i]) < dead[i]) || (run[i] > 0 && (((run[i] - 1) / bfr[i]) % 2) == 1);
            exp_seg[i] = blank ? 7'h7F : snap[i][dig];
            exp_an[i] = blank ? 4'hF : 4'(~(4'b0001 << dig));
            exp_fr[i] = (p == 0);
            pos[i] = p;
            n[i]++;
        end
        #1;
    endtask

    task automatic wait_pos(input int target, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            tick();
            if (pos[0] == target) ok = 1'b1;
        end
    endtask

    task automatic set_digits(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                              input logic [6:0] d);
        for (int i = 0; i < NI; i++) begin
            sev[i][0] = a;
            sev[i][1] = b;
            sev[i][2] = c;
            sev[i][3] = d;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_digits(7'h7F, 7'h7F, 7'h7F, 7'h7F);
        blink[0] = 1'b0;
        blink[1] = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            tests_run++;
            if (seg_w[i] !== 7'h7F || an_w[i] !== 4'hF || fr_w[i] !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_state inst%0d got seg=%h an=%b frame=%b want seg=7f an=1111 frame=0",
                         i, seg_w[i], an_w[i], fr_w[i]);
            end
        end
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < NI; i++) begin
            tests_run++;
            if (fr_w[i] !== 1'b1 || an_w[i] !== 4'hF || seg_w[i] !== 7'h7F) begin
                tests_failed++;
                $display("FAIL first_edge inst%0d got frame=%b an=%b seg=%h want frame=1 an=1111 seg=7f",
                         i, fr_w[i], an_w[i], seg_w[i]);
            end
        end
    endtask

    task automatic test_static_scan();
        int frames_seen;
        set_digits(7'h04, 7'h79, 7'h21, 7'h79);
        frames_seen = 0;
        for (int c = 0; c < 120; c++) begin
            tick();
            if (pos[0] == 0) frames_seen++;
            for (int i = 0; i < NI; i++) begin
                tests_run++;
                if (seg_w[i] !== exp_seg[i] || an_w[i] !== exp_an[i] || fr_w[i] !== exp_fr[i]) begin
                    tests_failed++;
                    $display("FAIL static_scan inst%0d p=%0d got seg=%h an=%b frame=%b want seg=%h an=%b frame=%b",
                             i, pos[i], seg_w[i], an_w[i], fr_w[i], exp_seg[i], exp_an[i], exp_fr[i]);
                end
            end
            if (frames_seen >= 1 && (pos[0] == 5 || pos[0] == 15 || pos[0] == 25 || pos[0] == 35)) begin
                logic [3:0] want_an;
                logic [6:0] want_seg;
                want_an  = (pos[0] == 5) ? 4'b1110 : (pos[0] == 15) ? 4'b1101 :
                           (pos[0] == 25) ? 4'b1011 : 4'b0111;
                want_seg = (pos[0] == 5) ? 7'h04 : (pos[0] == 25) ? 7'h21 : 7'h79;
                tests_run++;
                if (an0 !== want_an || seg0 !== want_seg) begin
                    tests_failed++;
                    $display("FAIL static_digit p=%0d got an=%b seg=%h want an=%b seg=%h",
                             pos[0], an0, seg0, want_an, want_seg);
                end
            end
            if (frames_seen >= 1 && (pos[0] % 10) < 2) begin
                tests_run++;
                if (an0 !== 4'hF || seg0 !== 7'h7F) begin
                    tests_failed++;
                    $display("FAIL static_dead p=%0d got an=%b seg=%h want an=1111 seg=7f", pos[0], an0, seg0);
                end
            end
        end
    endtask

    task automatic test_no_tearing();
        bit ok;
        int seen35;
        wait_pos(15, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL tear_wait got timeout want p=15");
        end
        sev[0][3] = 7'h30;
        sev[1][3] = 7'h30;
        seen35 = 0;
        for (int c = 0; c < 64; c++) begin
            tick();
            for (int i = 0; i < NI; i++) begin
                tests_run++;
                if (seg_w[i] !== exp_seg[i] || an_w[i] !== exp_an[i] || fr_w[i] !== exp_fr[i]) begin
                    tests_failed++;
                    $display("FAIL no_tearing inst%0d p=%0d got seg=%h an=%b frame=%b want seg=%h an=%b frame=%b",
                             i, pos[i], seg_w[i], an_w[i], fr_w[i], exp_seg[i], exp_an[i], exp_fr[i]);
                end
            end
            if (pos[0] == 35) begin
                tests_run++;
                if (seg0 !== ((seen35 == 0) ? 7'h79 : 7'h30) || an0 !== 4'b0111) begin
                    tests_failed++;
                    $display("FAIL tear_digit3 pass=%0d got seg=%h an=%b want seg=%h an=0111",
                             seen35, seg0, an0, (seen35 == 0) ? 7'h79 : 7'h30);
                end
                seen35++;
            end
        end
    endtask

    task automatic test_blink();
        bit ok;
        int vis0[9];
        int vis1[45];
        wait_pos(39, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL blink_wait got timeout want p=39");
        end
        foreach (vis0[f]) vis0[f] = 0;
        foreach (vis1[f]) vis1[f] = 0;
        blink[0] = 1'b1;
        blink[1] = 1'b1;
        for (int c = 0; c < 360; c++) begin
            tick();
            for (int i = 0; i < NI; i++) begin
                tests_run++;
                if (seg_w[i] !== exp_seg[i] || an_w[i] !== exp_an[i] || fr_w[i] !== exp_fr[i]) begin
                    tests_failed++;
                    $display("FAIL blink inst%0d p=%0d got seg=%h an=%b frame=%b want seg=%h an=%b frame=%b",
                             i, pos[i], seg_w[i], an_w[i], fr_w[i], exp_seg[i], exp_an[i], exp_fr[i]);
                end
            end
            if (an0 !== 4'hF) vis0[c / 40]++;
            if (an1 !== 4'hF) vis1[c / 8]++;
        end
        for (int f = 0; f < 9; f++) begin
            tests_run++;
            if (vis0[f] !== ((f >= 4 && f <= 7) ? 0 : 32)) begin
                tests_failed++;
                $display("FAIL blink_frame F%0d got %0d lit cycles want %0d", f, vis0[f],
                         (f >= 4 && f <= 7) ? 0 : 32);
            end
        end
        for (int f = 0; f < 45; f++) begin
            tests_run++;
            if (vis1[f] !== ((f % 2 == 0) ? 4 : 0)) begin
                tests_failed++;
                $display("FAIL blink_small F%0d got %0d lit cycles want %0d", f, vis1[f], (f % 2 == 0) ? 4 : 0);
            end
        end
    endtask

    task automatic test_blink_release();
        int vis_rest;
        int vis_next;
        int vis_re[5];
        for (int c = 0; c < 170; c++) begin
            tick();
            for (int i = 0; i < NI; i++) begin
                tests_run++;
                if (seg_w[i] !== exp_seg[i] || an_w[i] !== exp_an[i] || fr_w[i] !== exp_fr[i]) begin
                    tests_failed++;
                    $display("FAIL release_pre inst%0d p=%0d got seg=%h an=%b frame=%b want seg=%h an=%b frame=%b",
                             i, pos[i], seg_w[i], an_w[i], fr_w[i], exp_seg[i], exp_an[i], exp_fr[i]);
                end
            end
        end
        blink[0] = 1'b0;
        blink[1] = 1'b0;
        vis_rest = 0;
        vis_next = 0;
        foreach (vis_re[f]) vis_re[f] = 0;
        for (int c = 0; c < 270; c++) begin
            if (c == 70) begin
                blink[0] = 1'b1;
                blink[1] = 1'b1;
            end
            tick();
            for (int i = 0; i < NI; i++) begin
                tests_run++;
                if (seg_w[i] !== exp_seg[i] || an_w[i] !== exp_an[i] || fr_w[i] !== exp_fr[i]) begin
                    tests_failed++;
                    $display("FAIL release inst%0d p=%0d got seg=%h an=%b frame=%b want seg=%h an=%b frame=%b",
                             i, pos[i], seg_w[i], an_w[i], fr_w[i], exp_seg[i], exp_an[i], exp_fr[i]);
                end
            end
            if (an0 !== 4'hF) begin
                if (c < 30) vis_rest++;
                else if (c < 70) vis_next++;
                else vis_re[(c - 70) / 40]++;
            end
        end
        tests_run++;
        if (vis_rest !== 0) begin
            tests_failed++;
            $display("FAIL release_same_frame got %0d lit cycles want 0", vis_rest);
        end
        tests_run++;
        if (vis_next !== 32) begin
            tests_failed++;
            $display("FAIL release_next_frame got %0d lit cycles want 32", vis_next);
        end
        for (int f = 0; f < 5; f++) begin
            tests_run++;
            if (vis_re[f] !== ((f == 4) ? 0 : 32)) begin
                tests_failed++;
                $display("FAIL reassert F%0d got %0d lit cycles want %0d", f, vis_re[f], (f == 4) ? 0 : 32);
            end
        end
    endtask

    task automatic test_reset_mid_drive();
        bit ok;
        blink[0] = 1'b0;
        blink[1] = 1'b0;
        set_digits(7'h12, 7'h02, 7'h78, 7'h00);
        repeat (80) tick();
        wait_pos(5, ok);
        tests_run++;
        if (!ok || an0 !== 4'b1110 || seg0 !== 7'h12) begin
            tests_failed++;
            $display("FAIL pre_reset_drive got ok=%0d an=%b seg=%h want ok=1 an=1110 seg=12", ok, an0, seg0);
        end
        #2 reset_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            tests_run++;
            if (seg_w[i] !== 7'h7F || an_w[i] !== 4'hF || fr_w[i] !== 1'b0) begin
                tests_failed++;
                $display("FAIL async_reset inst%0d got seg=%h an=%b frame=%b want seg=7f an=1111 frame=0",
                         i, seg_w[i], an_w[i], fr_w[i]);
            end
        end
        model_reset();
        #2 reset_n = 1'b1;
        for (int c = 0; c < 80; c++) begin
            tick();
            for (int i = 0; i < NI; i++) begin
                tests_run++;
                if (seg_w[i] !== exp_seg[i] || an_w[i] !== exp_an[i] || fr_w[i] !== exp_fr[i]) begin
                    tests_failed++;
                    $display("FAIL post_reset inst%0d p=%0d got seg=%h an=%b frame=%b want seg=%h an=%b frame=%b",
                             i, pos[i], seg_w[i], an_w[i], fr_w[i], exp_seg[i], exp_an[i], exp_fr[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] prev_an[NI];
        for (int i = 0; i < NI; i++) prev_an[i] = an_w[i];
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NI; i++) begin
                if ($urandom_range(0, 7) == 0) sev[i][$urandom_range(0, 3)] = 7'($urandom);
                if ($urandom_range(0, 59) == 0) blink[i] = ~blink[i];
            end
            tick();
            for (int i = 0; i < NI; i++) begin
                tests_run++;
                if (seg_w[i] !== exp_seg[i] || an_w[i] !== exp_an[i] || fr_w[i] !== exp_fr[i]) begin
                    tests_failed++;
                    $display("FAIL random inst%0d p=%0d got seg=%h an=%b frame=%b want seg=%h an=%b frame=%b",
                             i, pos[i], seg_w[i], an_w[i], fr_w[i], exp_seg[i], exp_an[i], exp_fr[i]);
                end
                if (prev_an[i] !== 4'hF && an_w[i] !== 4'hF && prev_an[i] !== an_w[i]) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL enable_overlap inst%0d got an=%b after %b want dead gap", i, an_w[i], prev_an[i]);
                end
                prev_an[i] = an_w[i];
            end
        end
    endtask

    initial begin
        test_reset();
        test_static_scan();
        test_no_tearing();
        test_blink();
        test_blink_release();
        test_reset_mid_drive();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Time-multiplexed 4-digit seven-segment display driver. It sits directly downstream of the stopwatch FSM and consumes its four registered segment patterns (`o_seven0..3`) and its `o_done` flag. It drives one shared segment bus plus four digit-enable lines. It samples its inputs once per frame, so a mid-scan input change never tears the display, and it blinks the whole display while blink is requested.

## Interface
Parameters:
- `SCAN_CNT`, default 10: clocks per digit slot, including dead time.
- `DEAD_CNT`, default 2: blank cycles at the start of each slot (anti-ghosting). Legal range is 1 ≤ `DEAD_CNT` < `SCAN_CNT`.
- `BLINK_FRAMES`, default 4: frames per blink half-period. Must be ≥ 1.

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `i_seven0`..`i_seven3`  in  7 each  segment pattern for digit 0..3, active-low (`7'b111_1111` = all off)
- `i_blink`  in  1  blink request (driven from `o_done`)
- `o_seg`  out  7  shared segment bus, active-low
- `o_an`  out  4  digit enables, active-low; bit d enables digit d
- `o_frame`  out  1  one-cycle pulse marking a frame start

## Operation
- **Position counters**
  - `slot_cnt` runs 0..`SCAN_CNT`-1; `digit` runs 0..3.
  - `slot_cnt` wraps to 0 and `digit` increments (3→0) once per slot.
  - Frame position p = `digit`*`SCAN_CNT` + `slot_cnt`; frame length is 4*`SCAN_CNT` clocks.
- **Frame start** (edge where p becomes 0):
  - Snapshot `i_seven0..3` into shadow registers.
  - Sample `i_blink`.
  - `o_frame` = 1 for that cycle only.
  - Input changes at any other edge have no effect until the next frame start.
- **Per-slot phases**
  - DEAD (`slot_cnt` < `DEAD_CNT`): `o_an` = 4'b1111, `o_seg` = 7'b111_1111.
  - DRIVE (`slot_cnt` ≥ `DEAD_CNT`): `o_an` = ~(4'b0001 << `digit`), `o_seg` = shadow[`digit`].
- **Blink state** (`blink_en`, `phase`, frame counter k), updated only at frame-start edges:
  - Sampled `i_blink` = 0: `blink_en`←0, k←0, `phase`←0.
  - Sampled 1 and `blink_en` was 0: `blink_en`←1, k←0, `phase`←0.
  - Sampled 1, `blink_en` = 1, k = `BLINK_FRAMES`-1: k←0, `phase`←~`phase`.
  - Otherwise: k←k+1.
  - While `blink_en` & `phase` (values after the frame-start edge), the entire frame is forced blank (`o_an` = 4'b1111, `o_seg` = 7'b111_1111).
  - Result: `BLINK_FRAMES` visible frames, then `BLINK_FRAMES` blank frames, repeating. The first frame after blink asserts is always visible.
- **Outputs**: all registered; no combinational path from inputs to outputs.

## Timing
- **Reset** (asynchronous, takes effect immediately, including mid-frame):
  - `o_seg` = 7'b111_1111, `o_an` = 4'b1111, `o_frame` = 0.
  - `slot_cnt` = 0, `digit` = 0, shadows = 7'b111_1111, `blink_en` = 0, k = 0, `phase` = 0.
- **First edge after reset release** is a frame start (p = 0): `o_frame` = 1 and display blank (DEAD).
- **Default parameters**:
  - Digit d is driven for positions p = 10d+2 .. 10d+9 (8 cycles per slot).
  - Frame = 40 cycles; `o_frame` pulses every 40 cycles.
- **Input latency**: an input change is visible no earlier than the next frame start plus `DEAD_CNT` cycles (digit 0), and at most one frame + 3*`SCAN_CNT` + `DEAD_CNT` cycles later (digit 3).
- **Blink toggling**: blink deassertion mid-frame takes effect at the next frame start. The display resumes immediately (that frame visible) with `phase` cleared.
- **Enable exclusivity**: at most one `o_an` bit is low in any cycle. Two digits are never enabled in adjacent cycles, because every digit change is separated by ≥ `DEAD_CNT` all-off cycles.

## Test plan
1. **Reset blanking**: assert `reset_n` = 0 mid-DRIVE -> `o_an` = 4'b1111 and `o_seg` = 7'b111_1111 immediately. After release, `o_frame` = 1 on the first edge.
2. **Static scan**: drive `i_seven0..3` = 7'h04/7'h79/7'h21/7'h79, defaults -> per 40-cycle frame, `o_an` = 4'b1110 with `o_seg` = 7'h04 at p = 2..9, then 4'b1101/7'h79 at p = 12..19, 4'b1011/7'h21 at p = 22..29, 4'b0111/7'h79 at p = 32..39. All off at p = 0, 1, 10, 11, 20, 21, 30, 31.
3. **No tearing**: change `i_seven3` at p = 15 -> digit 3 shows the old value at p = 32..39 of this frame and the new value in the next frame.
4. **Blink**: hold `i_blink` = 1 from frame F0 -> frames F0–F3 visible, F4–F7 fully blank, F8 visible again.
5. **Blink release**: drop `i_blink` during a blank frame -> the next frame is visible, and blink restarts with 4 visible frames when re-asserted.
6. **Parameter corner**: `SCAN_CNT` = 2, `DEAD_CNT` = 1, `BLINK_FRAMES` = 1 -> 8-cycle frame, one drive cycle per digit, display alternates visible/blank every frame while blink is held.
